// File: rtl/baud_rate_controller.sv
// baud_rate_controller: 16x oversample tick generator with handshaked divisor changes applied at idle tick boundaries.
// Define BAUD_FRAC_EN to add a 4-bit fractional divisor (cfg_frac) driven by a phase accumulator.
module baud_rate_controller #(
  parameter int N = 16,
  parameter logic [N-1:0] DEF_DIV = 651,
  parameter int SETTLE_TICKS = 16
) (
  input  logic         clk_100MHz,
  input  logic         reset,
  input  logic [N-1:0] cfg_div,
`ifdef BAUD_FRAC_EN
  input  logic [3:0]   cfg_frac,
`endif
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic         uart_busy,
  output logic         tick,
  output logic [N-1:0] cur_div,
  output logic         cfg_done,
  output logic         cfg_err
);
  localparam int SW = $clog2(SETTLE_TICKS + 1);
  typedef enum logic [1:0] {RUN, DRAIN, LOAD, SETTLE} state_t;
  state_t state, state_nx;
  logic [N-1:0] counter, pend_div, period;
  logic [SW-1:0] settle_cnt;
  logic itick, accept, good_div, last_settle;
`ifdef BAUD_FRAC_EN
  logic [3:0] cur_frac, pend_frac, acc;
  logic ext;
  assign period = cur_div + N'(ext);
`else
  assign period = cur_div;
`endif
  assign itick = counter == period - N'(1);
  assign cfg_ready = state == RUN;
  assign tick = itick && (state == RUN || state == DRAIN);
  assign accept = cfg_ready && cfg_valid;
  assign good_div = cfg_div >= N'(2);
  assign last_settle = state == SETTLE && itick && settle_cnt == SW'(SETTLE_TICKS - 1);
  always_comb begin
    state_nx = state;
    state_nx = (state == RUN && accept && good_div) ? DRAIN :
               (state == DRAIN && itick && !uart_busy) ? LOAD :
               (state == LOAD) ? SETTLE :
               last_settle ? RUN : state;
  end
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      counter    <= '0;
      cur_div    <= DEF_DIV;
      pend_div   <= DEF_DIV;
      settle_cnt <= '0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state    <= state_nx;
      counter  <= (state == LOAD || itick) ? '0 : counter + N'(1);
      cfg_err  <= accept && !good_div;
      cfg_done <= last_settle;
      if (accept && good_div) pend_div <= cfg_div;
      if (state == LOAD) begin
        cur_div    <= pend_div;
        settle_cnt <= '0;
      end else if (state == SETTLE && itick) settle_cnt <= settle_cnt + SW'(1);
    end
  end
`ifdef BAUD_FRAC_EN
  // a carry out of the phase accumulator stretches the following period by one cycle
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      cur_frac  <= '0;
      pend_frac <= '0;
      acc       <= '0;
      ext       <= 1'b0;
    end else begin
      if (accept && good_div) pend_frac <= cfg_frac;
      if (state == LOAD) begin
        cur_frac <= pend_frac;
        acc      <= '0;
        ext      <= 1'b0;
      end else if (itick) {ext, acc} <= 5'(acc) + 5'(cur_frac);
    end
  end
`endif
endmodule

// File: tb/tb_baud_rate_controller.sv
// tb_baud_rate_controller: randomized divisor requests; expected tick/done/err times come from an arithmetic schedule model.
module tb_baud_rate_controller;
  localparam int N = 16;
  localparam int DEF = 651;
  typedef struct {int c; int d;} ev_t;
  logic clk_100MHz = 1'b0, reset = 1'b1;
  logic [N-1:0] cfg_div = '0;
  logic cfg_valid = 1'b0, uart_busy = 1'b0;
  logic cfg_ready, tick, cfg_done, cfg_err;
  logic [N-1:0] cur_div;
`ifdef BAUD_FRAC_EN
  logic [3:0] cfg_frac = '0;
`endif
  int tests = 0, fails = 0, cyc = 0;
  int cur = DEF, nxt = DEF - 1;
  int tick_q[$];
  ev_t done_q[$], err_q[$];

  baud_rate_controller dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .cfg_div(cfg_div),
`ifdef BAUD_FRAC_EN
    .cfg_frac(cfg_frac),
`endif
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .uart_busy(uart_busy),
    .tick(tick),
    .cur_div(cur_div),
    .cfg_done(cfg_done),
    .cfg_err(cfg_err)
  );

  always #5 clk_100MHz = ~clk_100MHz;
  always @(posedge clk_100MHz) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm, input int c);
    tests++;
    fails++;
    $display("FAIL missed %s: expected at cycle %0d", nm, c);
  endtask

  // monitor: every output event is matched against the front of its queue
  always @(negedge clk_100MHz) begin
    if (!reset) begin
      while (tick_q.size() > 0 && tick_q[0] < cyc) miss("tick", tick_q.pop_front());
      while (done_q.size() > 0 && done_q[0].c < cyc) miss("cfg_done", done_q.pop_front().c);
      while (err_q.size() > 0 && err_q[0].c < cyc) miss("cfg_err", err_q.pop_front().c);
      if (tick) begin
        chk("tick cycle", cyc, tick_q.size() > 0 ? tick_q[0] : -1);
        if (tick_q.size() > 0 && tick_q[0] == cyc) void'(tick_q.pop_front());
      end
      if (cfg_done) begin
        chk("cfg_done cycle", cyc, done_q.size() > 0 ? done_q[0].c : -1);
        if (done_q.size() > 0 && done_q[0].c == cyc) chk("cur_div at done", cur_div, done_q.pop_front().d);
      end
      if (cfg_err) begin
        chk("cfg_err cycle", cyc, err_q.size() > 0 ? err_q[0].c : -1);
        if (err_q.size() > 0 && err_q[0].c == cyc) chk("cur_div at err", cur_div, err_q.pop_front().d);
      end
      if (cfg_done || cfg_err) chk("done/err exclusive", cfg_done & cfg_err, 0);
    end
  end

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic advance(input int n);
    while (nxt < cyc + n) begin
      tick_q.push_back(nxt);
      nxt += cur;
    end
    repeat (n) step();
  endtask

  // one request of divisor d, uart_busy held for b cycles; abort_off>0 resets that many cycles into SETTLE
  task automatic request(input int d, input int b, input int abort_off);
    int h, t, s;
    h = cyc;
    cfg_div = N'(d);
    cfg_valid = 1'b1;
    uart_busy = b > 0;
    if (d < 2) begin
      err_q.push_back('{h + 1, cur});
      advance(1);
      cfg_valid = 1'b0;
      uart_busy = 1'b0;
      return;
    end
    t = nxt;
    while (t < h + (b > 1 ? b : 1)) t += cur;
    while (nxt <= t) begin
      tick_q.push_back(nxt);
      nxt += cur;
    end
    s = t + 1 + 16 * d;
    if (abort_off == 0) done_q.push_back('{s + 1, d});
    do begin
      step();
      cfg_div = N'(5);
      cfg_valid = (cyc <= s) && $urandom_range(3) == 0;
      uart_busy = (cyc < h + b) ? 1'b1 : (cyc > t && cyc <= s) ? 1'($urandom_range(1)) : 1'b0;
      chk("cfg_ready", cfg_ready, int'(cyc > s));
      if (cyc == t) chk("cur_div before load", cur_div, cur);
      if (cyc == t + 2) chk("cur_div after load", cur_div, d);
      if (abort_off > 0 && cyc == t + 2 + abort_off) begin
        reset = 1'b1;
        cfg_valid = 1'b0;
        uart_busy = 1'b0;
        #1;
        chk("reset cur_div", cur_div, DEF);
        chk("reset tick", tick, 0);
        chk("reset cfg_ready", cfg_ready, 1);
        chk("reset cfg_done", cfg_done, 0);
        repeat (3) step();
        reset = 1'b0;
        cur = DEF;
        nxt = DEF - 1;
        return;
      end
    end while (cyc <= s);
    cur = d;
    nxt = t + 1 + 17 * d;
  endtask

  initial begin
    repeat (3) step();
    chk("init cur_div", cur_div, DEF);
    chk("init cfg_ready", cfg_ready, 1);
    chk("init tick", tick, 0);
    chk("init cfg_done", cfg_done, 0);
    chk("init cfg_err", cfg_err, 0);
    reset = 1'b0;
    advance(3 * DEF);
    chk("idle cur_div", cur_div, DEF);
    request(1, 0, 0);
    advance(100);
    request(0, 0, 0);
    advance(200);
    chk("cur_div after rejects", cur_div, DEF);
    chk("cfg_ready after rejects", cfg_ready, 1);
    request(27, 3000, 0);
    advance(50);
    request(326, 0, 0);
    advance(400);
    request(2, 0, 0);
    advance(20);
    for (int i = 0; i < 14; i++) begin
      request(i == 4 ? cur : int'($urandom_range(0, 40)),
              $urandom_range(3) == 0 ? int'($urandom_range(1, 200)) : 0, 0);
      advance($urandom_range(1, 150));
    end
    request(100, 0, 300);
    advance(2 * DEF + 5);
    chk("cur_div after reset", cur_div, DEF);
    chk("ticks outstanding", tick_q.size(), 0);
    chk("done outstanding", done_q.size(), 0);
    chk("err outstanding", err_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
